// File: rtl/gbox_wl_gen_if.sv
// rtl/gbox_wl_gen_if.sv - control/status bundle between the gearbox word-load generator and its user
//
// Signals:
//   pll_lock      PLL lock indication (asynchronous to fast_clk)
//   rate_sel      requested serialization ratio, quasi-static
//   cfg_bypass    gearbox bypass, suppresses word loading
//   cfg_wl_phase  word-load phase offset (only with GBOX_WL_PHASE_EN)
//   word_load_en  one-cycle serializer load strobe
//   core_clk_div  divide-by-N fabric clock enable / reference
//   gen_ready     strobes running in steady state
// Modports: master drives configuration, slave is the generator.
// Optional feature macro: GBOX_WL_PHASE_EN.

interface gbox_wl_gen_if;
    logic       pll_lock;
    logic [3:0] rate_sel;
    logic       cfg_bypass;
`ifdef GBOX_WL_PHASE_EN
    logic [3:0] cfg_wl_phase;
`endif
    logic       word_load_en;
    logic       core_clk_div;
    logic       gen_ready;

    modport master (
`ifdef GBOX_WL_PHASE_EN
        output cfg_wl_phase,
`endif
        output pll_lock,
        output rate_sel,
        output cfg_bypass,
        input  word_load_en,
        input  core_clk_div,
        input  gen_ready
    );

    modport slave (
`ifdef GBOX_WL_PHASE_EN
        input  cfg_wl_phase,
`endif
        input  pll_lock,
        input  rate_sel,
        input  cfg_bypass,
        output word_load_en,
        output core_clk_div,
        output gen_ready
    );
endinterface

// File: rtl/gbox_wl_gen.sv
// rtl/gbox_wl_gen.sv - gearbox word-load strobe and divided fabric clock generator
//
// Ports:
//   fast_clk        sole clock, rising edge
//   system_reset_n  asynchronous active-low reset
//   bus             gbox_wl_gen_if.slave: pll_lock, rate_sel, cfg_bypass,
//                   [cfg_wl_phase], word_load_en, core_clk_div, gen_ready
// Parameters:
//   PAR_DWID    maximum serialization ratio (3..15)
//   PAR_SETTLE  synchronized-lock cycles required before word loading starts
// Optional feature macro: GBOX_WL_PHASE_EN adds the cfg_wl_phase load-phase offset.

module gbox_wl_gen #(
    parameter int PAR_DWID   = 10,
    parameter int PAR_SETTLE = 16
) (
    input  logic         fast_clk,
    input  logic         system_reset_n,
    gbox_wl_gen_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_RESYNC = 2'd3;

    localparam int          SW          = $clog2(PAR_SETTLE + 1);
    localparam logic [3:0]  DWID4       = 4'(PAR_DWID);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(PAR_SETTLE - 1);

    logic          lock_s1;
    logic          lock_s2;
    logic [1:0]    state;
    logic [SW-1:0] settle_cnt;
    logic [3:0]    cnt;
    logic [3:0]    n_lat;
    logic [3:0]    p_lat;
    logic          resync_cnt;
    logic          ccd_hold;
    logic          wle_q;
    logic          ccd_q;
    logic          gr_q;

    logic [3:0]    n_eff;
    logic [3:0]    p_eff;
    logic [4:0]    half_n;
    logic          cnt_last;
    logic          wl_hit;

    always_comb begin
        n_eff = bus.rate_sel;
        if (bus.rate_sel < 4'd3) begin
            n_eff = 4'd3;
        end else if (bus.rate_sel > DWID4) begin
            n_eff = DWID4;
        end
    end

`ifdef GBOX_WL_PHASE_EN
    // Out-of-range offsets fall back to the natural load point.
    assign p_eff = (bus.cfg_wl_phase < n_eff) ? bus.cfg_wl_phase : 4'd0;
`else
    assign p_eff = 4'd0;
`endif

    // ceil(N/2) needs 5 bits because N can be 15.
    assign half_n   = ({1'b0, n_lat} + 5'd1) >> 1;
    assign cnt_last = (cnt == n_lat - 4'd1);
    assign wl_hit   = (cnt == n_lat - 4'd1 - p_lat);

    always_ff @(posedge fast_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            lock_s1    <= 1'b0;
            lock_s2    <= 1'b0;
            state      <= ST_IDLE;
            settle_cnt <= '0;
            cnt        <= 4'd0;
            n_lat      <= 4'd0;
            p_lat      <= 4'd0;
            resync_cnt <= 1'b0;
            ccd_hold   <= 1'b0;
            wle_q      <= 1'b0;
            ccd_q      <= 1'b0;
            gr_q       <= 1'b0;
        end else begin
            lock_s1 <= bus.pll_lock;
            lock_s2 <= lock_s1;
            wle_q   <= 1'b0;
            ccd_q   <= 1'b0;
            gr_q    <= 1'b0;
            if (!lock_s2) begin
                state      <= ST_IDLE;
                settle_cnt <= '0;
                cnt        <= 4'd0;
                resync_cnt <= 1'b0;
                ccd_hold   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // The IDLE cycle that sees lock is the first settle cycle.
                        state      <= ST_SETTLE;
                        settle_cnt <= SW'(1);
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state      <= ST_RUN;
                            settle_cnt <= '0;
                            cnt        <= 4'd0;
                            n_lat      <= n_eff;
                            p_lat      <= p_eff;
                            ccd_hold   <= 1'b0;
                            gr_q       <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (n_eff != n_lat) begin
                            state      <= ST_RESYNC;
                            resync_cnt <= 1'b0;
                            cnt        <= 4'd0;
                        end else begin
                            gr_q  <= 1'b1;
                            cnt   <= cnt_last ? 4'd0 : cnt + 4'd1;
                            wle_q <= !bus.cfg_bypass && wl_hit;
                            // After bypass, the divided clock restarts only at a
                            // period boundary so no truncated high phase escapes.
                            ccd_q <= !bus.cfg_bypass && !ccd_hold && ({1'b0, cnt} < half_n);
                            if (bus.cfg_bypass) begin
                                ccd_hold <= 1'b1;
                            end else if (cnt_last) begin
                                ccd_hold <= 1'b0;
                            end
                        end
                    end
                    ST_RESYNC: begin
                        if (resync_cnt) begin
                            state      <= ST_RUN;
                            resync_cnt <= 1'b0;
                            cnt        <= 4'd0;
                            n_lat      <= n_eff;
                            p_lat      <= p_eff;
                            ccd_hold   <= 1'b0;
                            gr_q       <= 1'b1;
                        end else begin
                            resync_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.word_load_en = wle_q;
    assign bus.core_clk_div = ccd_q;
    assign bus.gen_ready    = gr_q;

endmodule

// File: tb/tb_gbox_wl_gen.sv
// tb/tb_gbox_wl_gen.sv - self-checking bench for gbox_wl_gen

module tb_gbox_wl_gen;
    localparam int DW = 10;
    localparam int PS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       lock_v = 1'b0;
    logic [3:0] rate_v = 4'd8;
    logic       byp_v  = 1'b0;
    logic [3:0] ph_v   = 4'd0;

    gbox_wl_gen_if bus();
    assign bus.pll_lock   = lock_v;
    assign bus.rate_sel   = rate_v;
    assign bus.cfg_bypass = byp_v;
`ifdef GBOX_WL_PHASE_EN
    assign bus.cfg_wl_phase = ph_v;
`endif

    gbox_wl_gen #(.PAR_DWID(DW), .PAR_SETTLE(PS)) dut (
        .fast_clk      (clk),
        .system_reset_n(rst_n),
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: lock seen through two flops; RUN begins once PS
    // consecutive synchronized-lock cycles have elapsed; inside RUN the
    // outputs follow from the age since RUN entry modulo N.
    bit m_s1, m_s2, m_run, m_gate;
    int m_hi, m_resync, m_age, m_n, m_p;
    bit e_wle, e_ccd, e_gr;

    function automatic int clamp_n(input int r);
        if (r < 3) return 3;
        if (r > DW) return DW;
        return r;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_run = 0; m_gate = 0;
        m_hi = 0; m_resync = 0; m_age = 0; m_n = 0; m_p = 0;
        e_wle = 0; e_ccd = 0; e_gr = 0;
    endtask

    task automatic model_enter(input int n, input int ph);
        m_run = 1; m_age = 0; m_n = n; m_gate = 0;
        m_p = (ph < n) ? ph : 0;
        e_gr = 1;
    endtask

    task automatic model_step(input bit lock, input int rate, input bit byp, input int ph);
        bit seen;
        int n_now;
        int pos;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = lock;
        n_now = clamp_n(rate);
        e_wle = 0; e_ccd = 0; e_gr = 0;
        if (!seen) begin
            m_hi = 0; m_run = 0; m_resync = 0;
            return;
        end
        m_hi++;
        if (!m_run) begin
            if (m_hi >= PS) model_enter(n_now, ph);
        end else if (m_resync > 0) begin
            m_resync--;
            if (m_resync == 0) model_enter(n_now, ph);
        end else if (n_now != m_n) begin
            m_resync = 2;
        end else begin
            pos = m_age % m_n;
            e_gr = 1;
            e_wle = !byp && (pos == m_n - 1 - m_p);
            e_ccd = !byp && !m_gate && (pos < (m_n + 1) / 2);
            if (byp) m_gate = 1;
            else if (pos == m_n - 1) m_gate = 0;
            m_age++;
        end
    endtask

    function automatic int ph_model();
`ifdef GBOX_WL_PHASE_EN
        return int'(ph_v);
`else
        return 0;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step(lock_v, int'(rate_v), byp_v, ph_model());
        #1;
        cyc++;
        check("model_outputs", int'({bus.word_load_en, bus.core_clk_div, bus.gen_ready}),
              int'({e_wle, e_ccd, e_gr}));
    endtask

    task automatic do_reset();
        lock_v = 0;
        byp_v = 0;
        #2;
        rst_n = 0;
        #12;
        check("reset_outputs", int'({bus.word_load_en, bus.core_clk_div, bus.gen_ready}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            lat++;
            if (bus.gen_ready) break;
        end
    endtask

    task automatic wait_strobe(output int k);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            k++;
            if (bus.word_load_en) break;
        end
    endtask

    task automatic measure_period(output int per, output int hi);
        per = 0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            per++;
            hi += int'(bus.core_clk_div);
            if (bus.word_load_en) break;
        end
    endtask

    typedef struct {
        logic [3:0] rate;
        int         period;
        int         high;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int lat, k, per, hi, t_last, cnt_a, cnt_b, cnt_c;

        tbl[0] = '{4'd8,  8,  4};
        tbl[1] = '{4'd1,  3,  2};
        tbl[2] = '{4'd12, 10, 5};
        tbl[3] = '{4'd0,  3,  2};
        tbl[4] = '{4'd3,  3,  2};
        tbl[5] = '{4'd4,  4,  2};
        tbl[6] = '{4'd5,  5,  3};
        tbl[7] = '{4'd7,  7,  4};
        tbl[8] = '{4'd10, 10, 5};
        tbl[9] = '{4'd15, 10, 5};

        model_reset();
        for (int i = 0; i < 10; i++) begin
            do_reset();
            rate_v = tbl[i].rate;
            ph_v = 4'd0;
            lock_v = 1;
            wait_ready(lat);
            check("ready_latency", lat, 18);
            wait_strobe(k);
            check("first_strobe_cycle", k, tbl[i].period);
            measure_period(per, hi);
            check("strobe_period", per, tbl[i].period);
            check("div_high_cycles", hi, tbl[i].high);
        end

        // Ratio change while running: two all-low cycles, then restart.
        do_reset();
        rate_v = 4'd4;
        lock_v = 1;
        wait_ready(lat);
        repeat (10) cycle();
        rate_v = 4'd6;
        cycle();
        check("resync_outputs_1", int'({bus.word_load_en, bus.core_clk_div, bus.gen_ready}), 0);
        cycle();
        check("resync_outputs_2", int'({bus.word_load_en, bus.core_clk_div, bus.gen_ready}), 0);
        cycle();
        check("resync_ready_back", int'(bus.gen_ready), 1);
        wait_strobe(k);
        check("resync_first_strobe", k, 6);
        measure_period(per, hi);
        check("resync_period", per, 6);

        // One-cycle lock glitch while running.
        repeat (5) cycle();
        lock_v = 0;
        cycle();
        lock_v = 1;
        cnt_a = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            cnt_a++;
            if (!bus.gen_ready) break;
        end
        check("lock_loss_delay", cnt_a, 3);
        cnt_b = 0;
        cnt_c = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            cnt_b++;
            if (bus.gen_ready) break;
            cnt_c += int'(bus.word_load_en) + int'(bus.core_clk_div);
        end
        check("relock_settle", cnt_b, 16);
        check("relock_spurious", cnt_c, 0);

        // Bypass for 20 cycles while running at ratio 8.
        do_reset();
        rate_v = 4'd8;
        lock_v = 1;
        wait_ready(lat);
        wait_strobe(k);
        t_last = cyc;
        byp_v = 1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        repeat (20) begin
            cycle();
            cnt_a += int'(bus.word_load_en);
            cnt_b += int'(bus.core_clk_div);
            cnt_c += int'(!bus.gen_ready);
        end
        check("bypass_strobes", cnt_a, 0);
        check("bypass_div", cnt_b, 0);
        check("bypass_ready_drops", cnt_c, 0);
        byp_v = 0;
        wait_strobe(k);
        check("bypass_cadence", (cyc - t_last) % 8, 0);
        measure_period(per, hi);
        check("bypass_after_period", per, 8);
        check("bypass_after_high", hi, 4);

`ifdef GBOX_WL_PHASE_EN
        do_reset();
        rate_v = 4'd5;
        ph_v = 4'd2;
        lock_v = 1;
        wait_ready(lat);
        wait_strobe(k);
        check("phase2_first_strobe", k, 3);
        do_reset();
        ph_v = 4'd7;
        lock_v = 1;
        wait_ready(lat);
        wait_strobe(k);
        check("phase7_first_strobe", k, 5);
        ph_v = 4'd0;
`endif

        // Asynchronous reset in the middle of a strobe.
        do_reset();
        rate_v = 4'd5;
        lock_v = 1;
        wait_ready(lat);
        wait_strobe(k);
        check("pre_reset_strobe", int'(bus.word_load_en), 1);
        #2;
        rst_n = 0;
        #1;
        check("async_reset_clear", int'({bus.word_load_en, bus.core_clk_div, bus.gen_ready}), 0);
        model_reset();
        lock_v = 0;
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the reference model.
        lock_v = 1;
        for (int i = 0; i < 2000; i++) begin
            cycle();
            if (!lock_v) begin
                if ($urandom_range(0, 1) == 0) lock_v = 1;
            end else if ($urandom_range(0, 149) == 0) begin
                lock_v = 0;
            end
            if ($urandom_range(0, 49) == 0) rate_v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) byp_v = ~byp_v;
            if ($urandom_range(0, 39) == 0) ph_v = 4'($urandom_range(0, 15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
